// File: rtl/clock_setter_if.sv
// Bus between clock_setter and its environment: set request, targets, live clock values,
// button drives back to the clock, and run status.
interface clock_setter_if;
    logic       Start;
    logic       Cancel;
    logic [6:0] TgtMin;
    logic [6:0] TgtHrs;
    logic       TgtPm;
    logic [2:0] TgtDay;
    logic [4:0] TgtDate;
    logic [3:0] TgtMonth;
    logic [6:0] TMin;
    logic [6:0] THrs;
    logic       TPm;
    logic [2:0] TDay;
    logic [4:0] TDate;
    logic [3:0] TMonth;
    logic       Timeset;
    logic       Monthadv;
    logic       Dateadv;
    logic       Dayadv;
    logic       Hrsadv;
    logic       Minadv;
    logic       Busy;
    logic       Done;
    logic       Err;

    modport master (
        output Start, Cancel, TgtMin, TgtHrs, TgtPm, TgtDay, TgtDate, TgtMonth,
        output TMin, THrs, TPm, TDay, TDate, TMonth,
        input  Timeset, Monthadv, Dateadv, Dayadv, Hrsadv, Minadv, Busy, Done, Err
    );

    modport slave (
        input  Start, Cancel, TgtMin, TgtHrs, TgtPm, TgtDay, TgtDate, TgtMonth,
        input  TMin, THrs, TPm, TDay, TDate, TMonth,
        output Timeset, Monthadv, Dateadv, Dayadv, Hrsadv, Minadv, Busy, Done, Err
    );
endinterface

// File: rtl/clock_setter.sv
// Steps a button-driven clock to a captured target time/date, one field at a time.
// Define SETTER_VERIFY_EN to add a final all-field VERIFY cycle after the minute field.
module clock_setter (
    input  logic          Pulse,
    input  logic          Reset,
    clock_setter_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CHECKARG = 4'd1,
        S_SETUP    = 4'd2,
        S_MONTH    = 4'd3,
        S_DATE     = 4'd4,
        S_DAY      = 4'd5,
        S_HRS      = 4'd6,
        S_MIN      = 4'd7,
`ifdef SETTER_VERIFY_EN
        S_VERIFY   = 4'd8,
`endif
        S_FINISH   = 4'd9,
        S_FAIL     = 4'd10
    } state_t;

    state_t     state_r;
    logic       phase_adv_r;
    logic [5:0] adv_cnt_r;
    logic [6:0] tgt_min_r;
    logic [6:0] tgt_hrs_r;
    logic       tgt_pm_r;
    logic [2:0] tgt_day_r;
    logic [4:0] tgt_date_r;
    logic [3:0] tgt_month_r;
    logic       timeset_r;
    logic [4:0] adv_r;
    logic       busy_r;
    logic       done_r;
    logic       err_r;

    logic       field_match_s;
    logic [4:0] field_adv_s;
    logic       targets_valid_s;
    state_t     field_next_s;

    // Field that follows the current one; the minute field hands over to the finish path.
    function automatic state_t next_field(input state_t cur);
        case (cur)
            S_MONTH: next_field = S_DATE;
            S_DATE:  next_field = S_DAY;
            S_DAY:   next_field = S_HRS;
            S_HRS:   next_field = S_MIN;
`ifdef SETTER_VERIFY_EN
            S_MIN:   next_field = S_VERIFY;
`else
            S_MIN:   next_field = S_FINISH;
`endif
            default: next_field = S_FAIL;
        endcase
    endfunction

    assign targets_valid_s = (tgt_min_r <= 7'd59) && (tgt_hrs_r <= 7'd11) &&
                             (tgt_day_r <= 3'd6) && (tgt_date_r <= 5'd30) &&
                             (tgt_month_r <= 4'd11);
    assign field_next_s = next_field(state_r);

    // Live-vs-target comparison and advance line for whichever field is being set.
    always_comb begin
        field_match_s = 1'b0;
        field_adv_s   = 5'b00000;
        case (state_r)
            S_MONTH: begin
                field_match_s = (bus.TMonth == tgt_month_r);
                field_adv_s   = 5'b10000;
            end
            S_DATE: begin
                field_match_s = (bus.TDate == tgt_date_r);
                field_adv_s   = 5'b01000;
            end
            S_DAY: begin
                field_match_s = (bus.TDay == tgt_day_r);
                field_adv_s   = 5'b00100;
            end
            S_HRS: begin
                // PM flips only when the clock wraps past 11, so both must agree.
                field_match_s = (bus.THrs == tgt_hrs_r) && (bus.TPm == tgt_pm_r);
                field_adv_s   = 5'b00010;
            end
            S_MIN: begin
                field_match_s = (bus.TMin == tgt_min_r);
                field_adv_s   = 5'b00001;
            end
            default: begin
                field_match_s = 1'b0;
                field_adv_s   = 5'b00000;
            end
        endcase
    end

`ifdef SETTER_VERIFY_EN
    logic all_match_s;
    assign all_match_s = (bus.TMonth == tgt_month_r) && (bus.TDate == tgt_date_r) &&
                         (bus.TDay == tgt_day_r) && (bus.THrs == tgt_hrs_r) &&
                         (bus.TPm == tgt_pm_r) && (bus.TMin == tgt_min_r);
`endif

    // Sequencer: state, advance counter, captured targets and all registered outputs.
    always_ff @(posedge Pulse) begin
        if (Reset) begin
            state_r     <= S_IDLE;
            phase_adv_r <= 1'b0;
            adv_cnt_r   <= 6'd0;
            tgt_min_r   <= 7'd0;
            tgt_hrs_r   <= 7'd0;
            tgt_pm_r    <= 1'b0;
            tgt_day_r   <= 3'd0;
            tgt_date_r  <= 5'd0;
            tgt_month_r <= 4'd0;
            timeset_r   <= 1'b0;
            adv_r       <= 5'b00000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else if ((state_r != S_IDLE) && bus.Cancel) begin
            state_r     <= S_IDLE;
            phase_adv_r <= 1'b0;
            adv_cnt_r   <= 6'd0;
            timeset_r   <= 1'b0;
            adv_r       <= 5'b00000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            adv_r  <= 5'b00000;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.Start) begin
                        state_r     <= S_CHECKARG;
                        tgt_min_r   <= bus.TgtMin;
                        tgt_hrs_r   <= bus.TgtHrs;
                        tgt_pm_r    <= bus.TgtPm;
                        tgt_day_r   <= bus.TgtDay;
                        tgt_date_r  <= bus.TgtDate;
                        tgt_month_r <= bus.TgtMonth;
                        busy_r      <= 1'b1;
                    end else begin
                        busy_r      <= 1'b0;
                    end
                    timeset_r <= 1'b0;
                end
                S_CHECKARG: begin
                    if (targets_valid_s) begin
                        state_r   <= S_SETUP;
                        timeset_r <= 1'b1;
                    end else begin
                        state_r   <= S_FAIL;
                        err_r     <= 1'b1;
                    end
                end
                S_SETUP: begin
                    state_r     <= S_MONTH;
                    phase_adv_r <= 1'b0;
                    adv_cnt_r   <= 6'd0;
                end
                S_MONTH, S_DATE, S_DAY, S_HRS, S_MIN: begin
                    if (phase_adv_r) begin
                        phase_adv_r <= 1'b0;
                    end else if (field_match_s) begin
                        state_r   <= field_next_s;
                        adv_cnt_r <= 6'd0;
                        if (field_next_s == S_FINISH) begin
                            timeset_r <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            timeset_r <= 1'b1;
                        end
                    end else if (adv_cnt_r == 6'd48) begin
                        state_r   <= S_FAIL;
                        adv_cnt_r <= 6'd0;
                        timeset_r <= 1'b0;
                        err_r     <= 1'b1;
                    end else begin
                        phase_adv_r <= 1'b1;
                        adv_cnt_r   <= adv_cnt_r + 6'd1;
                        adv_r       <= field_adv_s;
                    end
                end
`ifdef SETTER_VERIFY_EN
                S_VERIFY: begin
                    // Minute advances on some clocks carry into hours; catch that here.
                    timeset_r <= 1'b0;
                    if (all_match_s) begin
                        state_r <= S_FINISH;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= S_FAIL;
                        err_r   <= 1'b1;
                    end
                end
`endif
                S_FINISH, S_FAIL: begin
                    state_r   <= S_IDLE;
                    timeset_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state_r   <= S_IDLE;
                    timeset_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Timeset  = timeset_r;
    assign bus.Monthadv = adv_r[4];
    assign bus.Dateadv  = adv_r[3];
    assign bus.Dayadv   = adv_r[2];
    assign bus.Hrsadv   = adv_r[1];
    assign bus.Minadv   = adv_r[0];
    assign bus.Busy     = busy_r;
    assign bus.Done     = done_r;
    assign bus.Err      = err_r;

endmodule

// File: tb/tb_clock_setter.sv
// Bench for clock_setter: a behavioural button-driven clock plus a modular-arithmetic
// reference for expected pulse counts, outcome and latency; random and directed runs.
module tb_clock_setter;

    logic Pulse = 1'b0;
    logic Reset;
    clock_setter_if bus();

    clock_setter dut (
        .Pulse (Pulse),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Pulse = ~Pulse;

    int n_checks = 0;
    int n_pass   = 0;

    int month_len [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    // Behavioural clock driven by the advance buttons.
    int   clk_min, clk_hrs, clk_pm, clk_day, clk_date, clk_month;
    int   ld_min, ld_hrs, ld_pm, ld_day, ld_date, ld_month;
    logic load_req;

    always @(posedge Pulse) begin
        if (load_req) begin
            clk_min <= ld_min;  clk_hrs  <= ld_hrs;  clk_pm    <= ld_pm;
            clk_day <= ld_day;  clk_date <= ld_date; clk_month <= ld_month;
        end else begin
            if (bus.Minadv)   clk_min <= (clk_min + 1) % 60;
            if (bus.Hrsadv) begin
                if (clk_hrs == 11) begin
                    clk_hrs <= 0;
                    clk_pm  <= 1 - clk_pm;
                end else begin
                    clk_hrs <= clk_hrs + 1;
                end
            end
            if (bus.Dayadv)   clk_day  <= (clk_day + 1) % 7;
            if (bus.Dateadv)  clk_date <= (clk_date + 1 >= month_len[clk_month]) ? 0 : clk_date + 1;
            if (bus.Monthadv) clk_month <= (clk_month + 1) % 12;
        end
    end

    assign bus.TMin   = 7'(clk_min);
    assign bus.THrs   = 7'(clk_hrs);
    assign bus.TPm    = (clk_pm != 0);
    assign bus.TDay   = 3'(clk_day);
    assign bus.TDate  = 5'(clk_date);
    assign bus.TMonth = 4'(clk_month);

    // Cumulative output monitor; runs take deltas.
    int cnt_adv [5];
    int cnt_done, cnt_err, cnt_ts, viol;

    always @(negedge Pulse) begin
        if (bus.Monthadv) cnt_adv[0] <= cnt_adv[0] + 1;
        if (bus.Dateadv)  cnt_adv[1] <= cnt_adv[1] + 1;
        if (bus.Dayadv)   cnt_adv[2] <= cnt_adv[2] + 1;
        if (bus.Hrsadv)   cnt_adv[3] <= cnt_adv[3] + 1;
        if (bus.Minadv)   cnt_adv[4] <= cnt_adv[4] + 1;
        if (bus.Done)     cnt_done   <= cnt_done + 1;
        if (bus.Err)      cnt_err    <= cnt_err + 1;
        if (bus.Timeset)  cnt_ts     <= cnt_ts + 1;
        if (($countones({bus.Monthadv, bus.Dateadv, bus.Dayadv, bus.Hrsadv, bus.Minadv}) > 1) ||
            (!bus.Timeset && (bus.Monthadv || bus.Dateadv || bus.Dayadv || bus.Hrsadv || bus.Minadv)))
            viol <= viol + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge Pulse);
        #1;
    endtask

    function automatic logic [8:0] outs();
        return {bus.Timeset, bus.Monthadv, bus.Dateadv, bus.Dayadv, bus.Hrsadv,
                bus.Minadv, bus.Busy, bus.Done, bus.Err};
    endfunction

    function automatic int encode(input int mo, dt, dy, h, p, mi);
        return ((((mo * 31 + dt) * 7 + dy) * 12 + h) * 2 + p) * 60 + mi;
    endfunction

    task automatic load_clock(input int mo, dt, dy, h, p, mi);
        ld_month = mo; ld_date = dt; ld_day = dy; ld_hrs = h; ld_pm = p; ld_min = mi;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic drive_targets(input int mo, dt, dy, h, p, mi);
        bus.TgtMonth = 4'(mo); bus.TgtDate = 5'(dt); bus.TgtDay = 3'(dy);
        bus.TgtHrs = 7'(h); bus.TgtPm = (p != 0); bus.TgtMin = 7'(mi);
    endtask

    // One set request: reference expectation, then run with mid-run noise on Start/targets.
    task automatic run_set(input string name, input int mo, dt, dy, h, p, mi);
        int need [5];
        int exp_adv [5];
        int base_adv [5];
        int base_ts, sum, fail_f, exp_k, k, len;
        bit valid, seen, got_done, got_err;
        valid = (mi <= 59) && (h <= 11) && (dy <= 6) && (dt <= 30) && (mo <= 11);
        len = (mo <= 11) ? month_len[mo] : 31;
        need[0] = (mo - clk_month + 12) % 12;
        need[1] = (dt >= len) ? 1000 : (clk_date >= len) ? 1 + dt : (dt - clk_date + len) % len;
        need[2] = (dy - clk_day + 7) % 7;
        need[3] = ((h + 12 * p) - (clk_hrs + 12 * clk_pm) + 24) % 24;
        need[4] = (mi - clk_min + 60) % 60;
        fail_f = -1;
        sum = 0;
        for (int f = 0; f < 5; f++) begin
            exp_adv[f] = 0;
            if (valid && fail_f < 0) begin
                exp_adv[f] = (need[f] > 48) ? 48 : need[f];
                sum += exp_adv[f];
                if (need[f] > 48) fail_f = f;
            end
        end
        if (!valid) exp_k = 2;
        else if (fail_f >= 0) exp_k = 3 + 2 * sum + (fail_f + 1);
`ifdef SETTER_VERIFY_EN
        else exp_k = 9 + 2 * sum;
`else
        else exp_k = 8 + 2 * sum;
`endif
        for (int f = 0; f < 5; f++) base_adv[f] = cnt_adv[f];
        base_ts = cnt_ts;

        drive_targets(mo, dt, dy, h, p, mi);
        bus.Start = 1'b1;
        tick();
        k = 1;
        bus.Start = 1'b0;
        drive_targets($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 7),
                      $urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 127));
        seen = 1'b0;
        while (!seen && k < 400) begin
            if (bus.Done || bus.Err) begin
                seen = 1'b1;
            end else begin
                bus.Start = ($urandom_range(0, 3) == 0);
                tick();
                k++;
            end
        end
        bus.Start = 1'b0;
        got_done = bus.Done;
        got_err  = bus.Err;
        check_val({name, "_finished"}, 32'(seen), 32'd1);
        check_val({name, "_latency"}, k, exp_k);
        check_val({name, "_outcome"}, {got_done, got_err},
                  (valid && fail_f < 0) ? 32'd2 : 32'd1);
        check_val({name, "_ts_at_end"}, 32'(bus.Timeset), 32'd0);
        check_val({name, "_month_pulses"}, cnt_adv[0] - base_adv[0], exp_adv[0]);
        check_val({name, "_date_pulses"},  cnt_adv[1] - base_adv[1], exp_adv[1]);
        check_val({name, "_day_pulses"},   cnt_adv[2] - base_adv[2], exp_adv[2]);
        check_val({name, "_hrs_pulses"},   cnt_adv[3] - base_adv[3], exp_adv[3]);
        check_val({name, "_min_pulses"},   cnt_adv[4] - base_adv[4], exp_adv[4]);
        if (valid && fail_f < 0)
            check_val({name, "_clock_state"},
                      encode(clk_month, clk_date, clk_day, clk_hrs, clk_pm, clk_min),
                      encode(mo, dt, dy, h, p, mi));
        if (!valid)
            check_val({name, "_ts_never"}, cnt_ts - base_ts, 32'd0);
        tick();
        check_val({name, "_idle_after"}, {bus.Busy, bus.Done, bus.Err}, 32'd0);
    endtask

    initial begin
        int base [5];
        int base_done, base_err, n;
        bit seen;
        load_req   = 1'b0;
        Reset      = 1'b1;
        bus.Start  = 1'b0;
        bus.Cancel = 1'b0;
        drive_targets(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_val("reset_outputs", outs(), 9'd0);
        Reset = 1'b0;
        tick();

        load_clock(0, 0, 0, 0, 0, 0);
        run_set("example", 2, 4, 3, 5, 1, 30);

        load_clock(5, 10, 2, 7, 1, 15);
        run_set("already_set", 5, 10, 2, 7, 1, 15);

        run_set("bad_min", 5, 10, 2, 7, 1, 60);
        run_set("bad_month", 12, 0, 0, 0, 0, 0);

        load_clock(0, 0, 0, 0, 0, 0);
        run_set("feb_date30", 1, 30, 0, 0, 0, 0);

        load_clock(3, 3, 3, 3, 0, 0);
        run_set("min_48", 3, 3, 3, 3, 0, 48);
        run_set("min_49", 3, 3, 3, 3, 0, 37);

        // Cancel after the third hour pulse.
        load_clock(0, 0, 0, 0, 0, 0);
        for (int f = 0; f < 5; f++) base[f] = cnt_adv[f];
        base_done = cnt_done;
        base_err  = cnt_err;
        drive_targets(0, 0, 0, 8, 0, 0);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        n = 0;
        while ((cnt_adv[3] - base[3]) < 3 && n < 100) begin
            tick();
            n++;
        end
        bus.Cancel = 1'b1;
        tick();
        bus.Cancel = 1'b0;
        check_val("cancel_ts_busy", {bus.Timeset, bus.Busy}, 32'd0);
        check_val("cancel_no_done_err", {bus.Done, bus.Err}, 32'd0);
        repeat (20) tick();
        check_val("cancel_hrs_pulses", cnt_adv[3] - base[3], 32'd3);
        check_val("cancel_min_pulses", cnt_adv[4] - base[4], 32'd0);
        check_val("cancel_done_err_cnt", (cnt_done - base_done) + (cnt_err - base_err), 32'd0);

        // Reset while a minute pulse is on the line, with Start and Cancel also high.
        load_clock(0, 0, 0, 0, 0, 0);
        drive_targets(0, 0, 0, 0, 0, 40);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            if (bus.Minadv) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check_val("rst_minadv_seen", 32'(seen), 32'd1);
        Reset      = 1'b1;
        bus.Start  = 1'b1;
        bus.Cancel = 1'b1;
        tick();
        check_val("rst_mid_outputs", outs(), 9'd0);
        Reset      = 1'b0;
        bus.Start  = 1'b0;
        bus.Cancel = 1'b0;
        base[4] = cnt_adv[4];
        repeat (5) tick();
        check_val("rst_no_more_pulses", cnt_adv[4] - base[4], 32'd0);
        run_set("after_reset", 4, 7, 1, 9, 0, 12);

        // Randomized runs from random clock states, some with bad targets.
        for (int r = 0; r < 25; r++) begin
            int mo, dt, dy, h, p, mi, sel;
            mo = $urandom_range(0, 11);
            load_clock(mo, $urandom_range(0, month_len[mo] - 1), $urandom_range(0, 6),
                       $urandom_range(0, 11), $urandom_range(0, 1), $urandom_range(0, 59));
            mo = $urandom_range(0, 11);
            dt = $urandom_range(0, month_len[mo] - 1);
            dy = $urandom_range(0, 6);
            h  = $urandom_range(0, 11);
            p  = $urandom_range(0, 1);
            mi = $urandom_range(0, 59);
            sel = $urandom_range(0, 9);
            case (sel)
                0: mi = $urandom_range(60, 127);
                1: h  = $urandom_range(12, 127);
                2: dy = 7;
                3: dt = 31;
                4: mo = $urandom_range(12, 15);
                default: sel = sel;
            endcase
            run_set($sformatf("rand%0d", r), mo, dt, dy, h, p, mi);
        end

        check_val("protocol_violations", viol, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_setter.md
CLOCK_SETTER -- requirements
Module: clock_setter

Interface
REQ-001 SHALL have ports: Pulse  in  1  sole clock, all logic rising-edge; Reset  in  1  synchronous, active-high.
REQ-002 SHALL have inputs: Start 1 (request set); Cancel 1 (abort); TgtMin 7 (0-59); TgtHrs 7 (0-11, 0 displays as 12); TgtPm 1; TgtDay 3 (0-6); TgtDate 5 (0-30); TgtMonth 4 (0-11).
REQ-003 SHALL have inputs TMin 7, THrs 7, TPm 1, TDay 3, TDate 5, TMonth 4: live clock counter values, same encodings as targets.
REQ-004 SHALL have outputs, all registered: Timeset, Monthadv, Dateadv, Dayadv, Hrsadv, Minadv (button drives to clock); Busy; Done; Err.

Function
REQ-005 SHALL step the clock to the target time/date by driving Timeset plus single-cycle advance pulses, one field at a time.
REQ-006 States: IDLE, CHECKARG, SETUP, MONTH, DATE, DAY, HRS, MIN, VERIFY, FINISH, FAIL.
REQ-007 IDLE: Start=1 -> CHECKARG; Start while not IDLE SHALL be ignored.
REQ-008 CHECKARG: any target out of range (TgtMin>59, TgtHrs>11, TgtDay>6, TgtDate>30, TgtMonth>11) -> FAIL with Timeset never asserted; else -> SETUP.
REQ-009 SETUP: Timeset asserted one cycle with no advance line, freezing seconds; -> MONTH.
REQ-010 Field order SHALL be MONTH, DATE, DAY, HRS, MIN (month before date: date range depends on month).
REQ-011 Each field state alternates ADV and CHECK sub-cycles: CHECK compares live value to target; match -> next field; mismatch -> ADV cycle asserting that field's advance line for exactly one cycle, then CHECK.
REQ-012 HRS match condition SHALL be THrs==TgtHrs AND TPm==TgtPm; PM toggling is produced by the clock on wrap from 11.
REQ-013 Per-field advance count SHALL be 6 bits, cleared on field entry; 48 advances without match -> FAIL.
REQ-014 Timeset SHALL be high continuously from SETUP through last field/VERIFY and low in IDLE, CHECKARG, FINISH, FAIL.
REQ-015 At most one advance line SHALL be high in any cycle; none high while Timeset is low.
REQ-016 Busy SHALL be high in every state except IDLE.
REQ-017 FINISH: Done=1 for exactly one cycle, -> IDLE. FAIL: Err=1 for exactly one cycle, -> IDLE.
REQ-018 Cancel=1 in any non-IDLE state SHALL, next edge, drop all advance lines and Timeset and go to IDLE with Done=Err=0; Cancel takes priority over all transitions.
REQ-019 Target inputs SHALL be captured into internal registers on Start acceptance; later target changes have no effect on the run.
REQ-020 Target already equal to clock: sequence SHALL complete with zero advance pulses (SETUP plus one CHECK per field).

Reset
REQ-021 Reset=1 SHALL, at next edge, force IDLE, clear advance counter and captured targets, and drive all outputs 0; applies mid-operation with no further advance pulses.
REQ-022 Reset SHALL override Start and Cancel in the same cycle.

Configuration
REQ-023 Macro SETTER_VERIFY_EN defined: after MIN, VERIFY state re-compares all six fields in one cycle; all match -> FINISH, any mismatch -> FAIL (catches minute-advance carry side effects).
REQ-024 SETTER_VERIFY_EN undefined: MIN match -> FINISH directly; VERIFY state absent.

Verification
REQ-025 Clock at 12:00 AM, Jan(0) date 0 day 0; Start with Month 2, Date 4, Day 3, Hrs 5, Pm 1, Min 30 -> Monthadv x2, Dateadv x4, Dayadv x3, Hrsadv x17, Minadv x30, Done pulse, Timeset low after.
REQ-026 Start with TgtMin=60 -> Err pulse within 2 cycles, Timeset and all advance lines never high.
REQ-027 Targets equal clock state -> Done after SETUP + 5 CHECK cycles (+1 VERIFY with macro), zero advance pulses.
REQ-028 Cancel asserted mid-HRS after 3 Hrsadv pulses -> next cycle Timeset=0, Busy=0, no Done/Err, no further pulses.
REQ-029 Clock model whose date never reaches target 30 -> 48 Dateadv pulses then Err pulse, Busy low next cycle.
REQ-030 Reset asserted during MIN with Minadv high -> next edge all outputs 0, IDLE; subsequent Start runs full sequence normally.
